// File: rtl/hash_pkg.sv
// Shared hashing constants and types.
// Holds the SHA-256 word geometry, the initial chaining values H0..H7
// and the state encoding used by the digest stream reader. The H
// registers and the benches take these values from here.
package hash_pkg;

  localparam int WORD_W       = 32;
  localparam int DIGEST_WORDS = 8;

  // SHA-256 initial chaining values, H0 in the least significant word.
  localparam logic [DIGEST_WORDS*WORD_W-1:0] SHA256_H_INIT = {
    32'h5be0cd19,  // H7
    32'h1f83d9ab,  // H6
    32'h9b05688c,  // H5
    32'h510e527f,  // H4
    32'ha54ff53a,  // H3
    32'h3c6ef372,  // H2
    32'hbb67ae85,  // H1
    32'h6a09e667   // H0
  };

  // Reader states: IDLE waits for a capture, SEND streams words out.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/word_byteswap.sv
// Combinational byte reversal of one 32-bit word.
// Turns a big-endian SHA-256 word into the little-endian order used
// for block-hash display and target comparison.
module word_byteswap (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  assign dout = {din[7:0], din[15:8], din[23:16], din[31:24]};

endmodule

// File: rtl/digest_stream_reader.sv
// Digest stream reader.
// Captures the 256-bit chaining value H0..H7 in one cycle when a
// final block completes, then streams it as WORDS words (H0 first)
// over a valid/ready interface. A capture arriving while a digest is
// still in flight is dropped and flagged in the sticky overrun bit.
// A capture coinciding with the last transfer is accepted, so
// back-to-back digests stream without a bubble.
// Build option: define DIGEST_BYTESWAP_EN to byte-reverse every
// output word; otherwise words leave exactly as captured.
module digest_stream_reader #(
  parameter int WORDS  = 8,
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WORDS*WORD_W-1:0] h_in,
  input  logic                    cap_valid,
  output logic                    cap_ready,
  output logic [WORD_W-1:0]       dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic                    overrun,
  input  logic                    clr_overrun,
  output logic [CNT_W-1:0]        digest_cnt
);

  import hash_pkg::*;

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [WORDS*WORD_W-1:0] cap_reg;

  logic                    xfer;
  logic                    last_xfer;
  logic                    cap_take;
  logic [IDX_W-1:0]        next_idx;
  logic [WORD_W-1:0]       next_raw;
  logic [WORD_W-1:0]       next_word;
  logic                    next_last;

  // A transfer happens whenever the presented word is accepted.
  assign xfer      = dout_valid && dout_ready;
  assign last_xfer = xfer && dout_last;

  // Idle, or the in-flight digest finishes this very cycle.
  assign cap_ready = (state == IDLE) || last_xfer;
  assign cap_take  = cap_valid && cap_ready;

  // Select the word that will be presented after this clock edge.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    next_idx = idx + IDX_W'(1);
    next_raw = cap_reg[next_idx*WORD_W +: WORD_W];
    if (cap_take) begin
      next_idx = '0;
      next_raw = h_in[WORD_W-1:0];
    end
  end

  assign next_last = (next_idx == IDX_W'(WORDS - 1));

`ifdef DIGEST_BYTESWAP_EN
  word_byteswap u_word_byteswap (
    .din  (next_raw),
    .dout (next_word)
  );
`else
  assign next_word = next_raw;
`endif

  // Reader FSM with registered stream outputs, overrun flag and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the capture register is a plain datapath register and is
      // cleared with everything else so dout never exposes stale data.
      state      <= IDLE;
      idx        <= '0;
      cap_reg    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      overrun    <= 1'b0;
      digest_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads
      // the pre-edge values of the state registers.
      if (cap_valid && !cap_ready) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end

      if (last_xfer) begin
        digest_cnt <= digest_cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (cap_valid) begin
            cap_reg    <= h_in;
            idx        <= next_idx;
            dout       <= next_word;
            dout_last  <= next_last;
            dout_valid <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (dout_last) begin
              if (cap_valid) begin
                cap_reg   <= h_in;
                idx       <= next_idx;
                dout      <= next_word;
                dout_last <= next_last;
              end else begin
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
                state      <= IDLE;
              end
            end else begin
              idx       <= next_idx;
              dout      <= next_word;
              dout_last <= next_last;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
